// File: rtl/code_loader_if.sv
// Program-load stream in, instruction-memory write port and loader status out.
// The slave modport is the loader; the master modport is its environment.
interface code_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  load_start;
  logic                  cpu_idle;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] inst_wr_addr;
  logic [DATA_WIDTH-1:0] inst_wr_data;
  logic                  inst_wr_en;
  logic [ADDR_WIDTH:0]   prog_len;
  logic                  prog_valid;
  logic                  busy;
  logic                  load_err;

  modport master (
    output load_start, cpu_idle, load_data, load_valid, load_last,
    input  load_ready, inst_wr_addr, inst_wr_data, inst_wr_en,
    input  prog_len, prog_valid, busy, load_err
  );

  modport slave (
    input  load_start, cpu_idle, load_data, load_valid, load_last,
    output load_ready, inst_wr_addr, inst_wr_data, inst_wr_en,
    output prog_len, prog_valid, busy, load_err
  );
endinterface

// File: rtl/code_loader.sv
// Streams a program into instruction memory once the CPU is idle; each accepted word is written one cycle later.
// Backpressure: load_ready is high only while loading, and is dropped in the cycle of a restart.
module code_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  code_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   plen;
  logic                  pv;
  logic                  err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ready;
  logic                  accept;

  // A restart pulse takes priority over any beat offered in the same cycle.
  assign ready  = (state == LOAD) && !bus.load_start;
  assign accept = ready && bus.load_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      plen    <= '0;
      pv      <= 1'b0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= count[ADDR_WIDTH-1:0];
        wr_data <= bus.load_data;
        count   <= count + ONE;
      end
      if (bus.load_start) begin
        state <= WAIT_IDLE;
        count <= '0;
        pv    <= 1'b0;
        err   <= 1'b0;
      end else begin
        case (state)
          WAIT_IDLE: if (bus.cpu_idle) state <= LOAD;
          LOAD: begin
            if (accept) begin
              if (bus.load_last) begin
                state <= DONE;
                plen  <= count + ONE;
              end else if (count == LAST_IDX) begin
                // Overflowing word is still written; the program is just never marked valid.
                state <= ERR;
                err   <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            pv    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.load_ready   = ready;
  assign bus.busy         = (state != IDLE);
  assign bus.inst_wr_en   = wr_en;
  assign bus.inst_wr_addr = wr_addr;
  assign bus.inst_wr_data = wr_data;
  assign bus.prog_len     = plen;
  assign bus.prog_valid   = pv;
  assign bus.load_err     = err;

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader with a 4-word memory: cycle-vector table, reset corners, random programs vs a transaction model.
module tb_code_loader;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  code_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) bus ();

  code_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  inp;    // start, cpu_idle, valid, last
    logic [15:0] d;
    logic [2:0]  flg;    // ready, busy, wr_en
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  st;     // prog_valid, load_err
    logic [2:0]  plen;
  } vec_t;

  vec_t tbl[$];

  logic [1:0]  mon_a[$];
  logic [15:0] mon_d[$];

  always @(negedge clk) begin
    if (bus.inst_wr_en) begin
      mon_a.push_back(bus.inst_wr_addr);
      mon_d.push_back(bus.inst_wr_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic [3:0] inp, input logic [15:0] d, input logic [2:0] flg,
                     input logic [1:0] wa, input logic [15:0] wd, input logic [1:0] st,
                     input logic [2:0] plen);
    vec_t v;
    v.inp = inp; v.d = d; v.flg = flg; v.wa = wa; v.wd = wd; v.st = st; v.plen = plen;
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_plen;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.load_start = 1'b0; bus.cpu_idle = 1'b0; bus.load_valid = 1'b0;
    bus.load_last  = 1'b0; bus.load_data = 16'h0;

    // Normal load, gapped stream, overflow, ERR exit, restart mid-load, length-1 program.
    add(4'b1000, 16'h0000, 3'b000, 2'd0, 16'h0000, 2'b00, 3'd0);
    add(4'b0000, 16'h0000, 3'b010, 2'd0, 16'h0000, 2'b00, 3'd0);
    add(4'b0000, 16'h0000, 3'b010, 2'd0, 16'h0000, 2'b00, 3'd0);
    add(4'b0100, 16'h0000, 3'b010, 2'd0, 16'h0000, 2'b00, 3'd0);
    add(4'b0010, 16'hA000, 3'b110, 2'd0, 16'h0000, 2'b00, 3'd0);
    add(4'b0010, 16'hA001, 3'b111, 2'd0, 16'hA000, 2'b00, 3'd0);
    add(4'b0000, 16'h0000, 3'b111, 2'd1, 16'hA001, 2'b00, 3'd0);
    add(4'b0010, 16'hA002, 3'b110, 2'd1, 16'hA001, 2'b00, 3'd0);
    add(4'b0011, 16'hA003, 3'b111, 2'd2, 16'hA002, 2'b00, 3'd0);
    add(4'b0000, 16'h0000, 3'b011, 2'd3, 16'hA003, 2'b00, 3'd4);
    add(4'b0000, 16'h0000, 3'b000, 2'd3, 16'hA003, 2'b10, 3'd4);
    add(4'b1000, 16'h0000, 3'b000, 2'd3, 16'hA003, 2'b10, 3'd4);
    add(4'b0100, 16'h0000, 3'b010, 2'd3, 16'hA003, 2'b00, 3'd4);
    add(4'b0010, 16'hB000, 3'b110, 2'd3, 16'hA003, 2'b00, 3'd4);
    add(4'b0010, 16'hB001, 3'b111, 2'd0, 16'hB000, 2'b00, 3'd4);
    add(4'b0010, 16'hB002, 3'b111, 2'd1, 16'hB001, 2'b00, 3'd4);
    add(4'b0010, 16'hB003, 3'b111, 2'd2, 16'hB002, 2'b00, 3'd4);
    add(4'b0010, 16'hB004, 3'b011, 2'd3, 16'hB003, 2'b01, 3'd4);
    add(4'b0010, 16'hB004, 3'b010, 2'd3, 16'hB003, 2'b01, 3'd4);
    add(4'b1100, 16'h0000, 3'b010, 2'd3, 16'hB003, 2'b01, 3'd4);
    add(4'b0100, 16'h0000, 3'b010, 2'd3, 16'hB003, 2'b00, 3'd4);
    add(4'b0010, 16'hC000, 3'b110, 2'd3, 16'hB003, 2'b00, 3'd4);
    add(4'b1010, 16'hC001, 3'b011, 2'd0, 16'hC000, 2'b00, 3'd4);
    add(4'b0110, 16'hC002, 3'b010, 2'd0, 16'hC000, 2'b00, 3'd4);
    add(4'b0011, 16'hC003, 3'b110, 2'd0, 16'hC000, 2'b00, 3'd4);
    add(4'b0000, 16'h0000, 3'b011, 2'd0, 16'hC003, 2'b00, 3'd1);
    add(4'b0000, 16'h0000, 3'b000, 2'd0, 16'hC003, 2'b10, 3'd1);

    step;
    chk("rst_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.load_ready), 32'd0);
    chk("post_rst_busy",  32'(bus.busy),       32'd0);
    chk("post_rst_plen",  32'(bus.prog_len),   32'd0);
    step;

    foreach (tbl[i]) begin
      bus.load_start = tbl[i].inp[3];
      bus.cpu_idle   = tbl[i].inp[2];
      bus.load_valid = tbl[i].inp[1];
      bus.load_last  = tbl[i].inp[0];
      bus.load_data  = tbl[i].d;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(bus.load_ready),   32'(tbl[i].flg[2]));
      chk($sformatf("row%0d_busy", i),  32'(bus.busy),         32'(tbl[i].flg[1]));
      chk($sformatf("row%0d_wr_en", i), 32'(bus.inst_wr_en),   32'(tbl[i].flg[0]));
      chk($sformatf("row%0d_addr", i),  32'(bus.inst_wr_addr), 32'(tbl[i].wa));
      chk($sformatf("row%0d_data", i),  32'(bus.inst_wr_data), 32'(tbl[i].wd));
      chk($sformatf("row%0d_pvalid", i),32'(bus.prog_valid),   32'(tbl[i].st[1]));
      chk($sformatf("row%0d_err", i),   32'(bus.load_err),     32'(tbl[i].st[0]));
      chk($sformatf("row%0d_plen", i),  32'(bus.prog_len),     32'(tbl[i].plen));
      step;
    end

    // Asynchronous reset between edges while a write is being issued.
    bus.load_start = 1'b1; bus.cpu_idle = 1'b1; bus.load_valid = 1'b0; bus.load_last = 1'b0;
    step;
    bus.load_start = 1'b0;
    step;
    bus.load_valid = 1'b1; bus.load_data = 16'h5A5A;
    #1;
    chk("arst_pre_ready", 32'(bus.load_ready), 32'd1);
    step;
    bus.load_valid = 1'b0;
    #1;
    chk("arst_pre_wr_en", 32'(bus.inst_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_wr_en",  32'(bus.inst_wr_en),   32'd0);
    chk("arst_addr",   32'(bus.inst_wr_addr), 32'd0);
    chk("arst_data",   32'(bus.inst_wr_data), 32'd0);
    chk("arst_plen",   32'(bus.prog_len),     32'd0);
    chk("arst_pvalid", 32'(bus.prog_valid),   32'd0);
    chk("arst_err",    32'(bus.load_err),     32'd0);
    chk("arst_busy",   32'(bus.busy),         32'd0);
    chk("arst_ready",  32'(bus.load_ready),   32'd0);
    step;
    chk("arst_hold_wr_en", 32'(bus.inst_wr_en), 32'd0);
    rst = 1'b0;
    step;

    // Random programs against a transaction-level model of the memory image.
    exp_plen = 0;
    for (int p = 0; p < 40; p++) begin
      int len;
      int idx;
      int budget;
      int n_exp;
      bit seen;
      logic [15:0] w[$];
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) w.push_back(16'($urandom));
      mon_a.delete();
      mon_d.delete();
      bus.load_start = 1'b1; bus.load_valid = 1'b0; bus.load_last = 1'b0;
      bus.cpu_idle = 1'($urandom_range(0, 1));
      step;
      bus.load_start = 1'b0;
      bus.cpu_idle   = 1'b0;
      repeat ($urandom_range(0, 3)) step;
      bus.cpu_idle = 1'b1;
      idx = 0; budget = 0; seen = 1'b0;
      while (idx < len && budget < 30) begin
        bus.load_valid = ($urandom_range(0, 3) != 0);
        bus.load_data  = w[idx];
        bus.load_last  = (idx == len - 1);
        if (seen) bus.cpu_idle = 1'($urandom_range(0, 1));
        #1;
        if (bus.load_ready) seen = 1'b1;
        if (bus.load_ready && bus.load_valid) idx++;
        budget++;
        step;
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      repeat (3) step;

      n_exp = (len > 4) ? 4 : len;
      if (len <= 4) exp_plen = len;
      chk($sformatf("rnd%0d_wr_count", p), 32'(mon_a.size()), 32'(n_exp));
      for (int k = 0; k < n_exp && k < mon_a.size(); k++) begin
        chk($sformatf("rnd%0d_addr%0d", p, k), 32'(mon_a[k]), 32'(k));
        chk($sformatf("rnd%0d_data%0d", p, k), 32'(mon_d[k]), 32'(w[k]));
      end
      chk($sformatf("rnd%0d_plen", p),   32'(bus.prog_len),   32'(exp_plen));
      chk($sformatf("rnd%0d_pvalid", p), 32'(bus.prog_valid), 32'(len <= 4));
      chk($sformatf("rnd%0d_err", p),    32'(bus.load_err),   32'(len > 4));
      chk($sformatf("rnd%0d_busy", p),   32'(bus.busy),       32'(len > 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
